// File: rtl/seq_frame_capture.sv
// Serial frame capture: after a sync-pattern detect pulse, shifts in WIDTH payload
// bits (first bit lands in MSB) and hands the frame to a ready/valid output stage.
module seq_frame_capture #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             det,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [WIDTH-1:0] dout_n;
  logic             dv_n, ovr_n, done;
  logic [CNT_W-1:0] fc_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sr         <= sr_n;
      data_out   <= dout_n;
      data_valid <= dv_n;
      overrun    <= ovr_n;
      frame_cnt  <= fc_n;
      busy       <= (state_n == CAPTURE);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    dout_n  = data_out;
    dv_n    = data_valid;
    ovr_n   = overrun & ~clr_ovr;
    fc_n    = frame_cnt;
    done    = 1'b0;

    case (state)
      IDLE: begin
        if (det) begin
          state_n = CAPTURE;
          cnt_n   = '0;
        end
      end
      CAPTURE: begin
        sr_n  = {sr[WIDTH-2:0], in};
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          done    = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    // A completing frame may replace a pending one only if it is being accepted now;
    // otherwise it is dropped and overrun wins over a same-edge clear.
    if (done) begin
      if (!data_valid || out_ready) begin
        dout_n = sr_n;
        dv_n   = 1'b1;
        fc_n   = frame_cnt + 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end else if (data_valid && out_ready) begin
      dv_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_frame_capture.sv
// Self-checking bench for seq_frame_capture: frame-level vector table, directed
// corner sequences and randomized traffic against a bit-queue reference model.
module tb_seq_frame_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in = 1'b0, det = 1'b0, out_ready = 1'b0, clr_ovr = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, overrun, busy;
  logic [7:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  seq_frame_capture #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in(in), .det(det), .out_ready(out_ready),
    .clr_ovr(clr_ovr), .data_out(data_out), .data_valid(data_valid),
    .overrun(overrun), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a list of payload bits collected since the last accepted detect.
  bit         m_cap;
  bit         m_bits[$];
  logic [7:0] m_dout;
  logic       m_dv, m_ovr;
  logic [7:0] m_fc;

  task automatic model_reset();
    m_cap = 0; m_bits.delete();
    m_dout = '0; m_dv = 0; m_ovr = 0; m_fc = '0;
  endtask

  task automatic model_edge(input logic i, input logic d, input logic r, input logic c);
    bit         done;
    logic [7:0] frame;
    logic       nov;
    done = 0; frame = '0;
    if (m_cap) begin
      m_bits.push_back(i);
      if (m_bits.size() == 8) begin
        foreach (m_bits[k]) frame = (frame << 1) | 8'(m_bits[k]);
        done = 1; m_cap = 0; m_bits.delete();
      end
    end else if (d) begin
      m_cap = 1; m_bits.delete();
    end
    nov = m_ovr && !c;
    if (done) begin
      if (!m_dv || r) begin m_dout = frame; m_dv = 1; m_fc = m_fc + 8'd1; end
      else nov = 1;
    end else if (m_dv && r) m_dv = 0;
    m_ovr = nov;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("data_out", 32'(data_out), 32'(m_dout));
    check("data_valid", 32'(data_valid), 32'(m_dv));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("frame_cnt", 32'(frame_cnt), 32'(m_fc));
    check("busy", 32'(busy), 32'(m_cap));
  endtask

  task automatic step(input logic i, input logic d, input logic r, input logic c);
    in = i; det = d; out_ready = r; clr_ovr = c;
    model_edge(i, d, r, c);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic send_frame(input logic [7:0] p, input logic rdy);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 7; k >= 0; k--) step(p[k], 1'b0, (k == 0) ? rdy : 1'b0, 1'b0);
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b0; in = 0; det = 0; out_ready = 0; clr_ovr = 0;
    #1;
    model_reset();
    check("rst_async_dout", 32'(data_out), 32'h0);
    check("rst_async_dv", 32'(data_valid), 32'h0);
    check("rst_async_ovr", 32'(overrun), 32'h0);
    check("rst_async_fc", 32'(frame_cnt), 32'h0);
    check("rst_async_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    check_model();
    #2;
    rst = 1'b1;
  endtask

  typedef struct {
    logic [7:0] payload;
    logic       rdy;
    logic [7:0] e_dout;
    logic       e_dv;
    logic       e_ovr;
    logic [7:0] e_fc;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic       ri, rd, rr, rc;
    logic [7:0] rp;

    vt[0] = '{8'hB2, 1'b0, 8'hB2, 1'b1, 1'b0, 8'd1};
    vt[1] = '{8'h5A, 1'b0, 8'hB2, 1'b1, 1'b1, 8'd1};
    vt[2] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b1, 8'd2};
    vt[3] = '{8'hC3, 1'b1, 8'hC3, 1'b1, 1'b1, 8'd3};
    vt[4] = '{8'h00, 1'b0, 8'hC3, 1'b1, 1'b1, 8'd3};

    model_reset();
    #3;
    check_model();
    @(posedge clk);
    #1;
    check_model();
    #2;
    rst = 1'b1;

    for (int v = 0; v < 5; v++) begin
      send_frame(vt[v].payload, vt[v].rdy);
      check("vec_dout", 32'(data_out), 32'(vt[v].e_dout));
      check("vec_dv", 32'(data_valid), 32'(vt[v].e_dv));
      check("vec_ovr", 32'(overrun), 32'(vt[v].e_ovr));
      check("vec_fc", 32'(frame_cnt), 32'(vt[v].e_fc));
    end

    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_ovr", 32'(overrun), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("accept_dv", 32'(data_valid), 32'h0);
    check("accept_hold", 32'(data_out), 32'hC3);

    // Detect pulses inside a payload are ignored; back-to-back frame starts immediately.
    rp = 8'hA5;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 7; k >= 0; k--)
      step(rp[k], (k == 5 || k == 3), (k == 0), 1'b0);
    check("ovl_busy_done", 32'(busy), 32'h0);
    check("ovl_dout", 32'(data_out), 32'hA5);
    check("ovl_fc", 32'(frame_cnt), 32'd4);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("b2b_busy", 32'(busy), 32'h1);
    check("b2b_dv", 32'(data_valid), 32'h0);
    rp = 8'h69;
    for (int k = 7; k >= 0; k--) step(rp[k], 1'b0, 1'b0, 1'b0);
    check("b2b_dout", 32'(data_out), 32'h69);
    check("b2b_dv2", 32'(data_valid), 32'h1);
    check("b2b_fc", 32'(frame_cnt), 32'd5);

    // Reset in the middle of a frame.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("abort_dv", 32'(data_valid), 32'h0);
    send_frame(8'h81, 1'b0);
    check("post_rst_dout", 32'(data_out), 32'h81);
    check("post_rst_fc", 32'(frame_cnt), 32'd1);

    for (int n = 0; n < 2000; n++) begin
      ri = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 3) == 0);
      rr = 1'($urandom_range(0, 1));
      rc = ($urandom_range(0, 7) == 0);
      step(ri, rd, rr, rc);
    end

    do_reset();
    for (int n = 0; n < 256; n++) begin
      rp = 8'($urandom);
      send_frame(rp, 1'b1);
    end
    check("wrap_fc", 32'(frame_cnt), 32'h0);
    check("wrap_ovr", 32'(overrun), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
